// File: rtl/rggen_apb_bridge_if.sv
// Signal bundle between an rggen register-bus host, the APB bridge and an APB completer.
// The master modport is the bridge itself; the slave modport is the host-plus-completer side.
interface rggen_apb_bridge_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      bus_request;
    logic [ADDRESS_WIDTH-1:0]  bus_address;
    logic                      bus_direction;
    logic [DATA_WIDTH-1:0]     bus_write_data;
    logic [DATA_WIDTH/8-1:0]   bus_write_strobe;
    logic                      bus_done;
    logic [DATA_WIDTH-1:0]     bus_read_data;
    logic [1:0]                bus_status;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic                      pslverr;
    logic [DATA_WIDTH-1:0]     prdata;

    modport master (
        input  bus_request, bus_address, bus_direction, bus_write_data, bus_write_strobe,
        output bus_done, bus_read_data, bus_status,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        output bus_request, bus_address, bus_direction, bus_write_data, bus_write_strobe,
        input  bus_done, bus_read_data, bus_status,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/rggen_apb_bridge.sv
// rggen register-bus to APB3/APB4 master bridge with an optional ACCESS-phase timeout.
module rggen_apb_bridge #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                clk,
    input logic                rst_n,
    rggen_apb_bridge_if.master bridge
);
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPOND
    } state_e;

    state_e                 state;
    logic [COUNT_WIDTH-1:0] timeout_count;
    logic                   timeout_hit;

    // With TIMEOUT_CYCLES == 0 the compare is never enabled and the counter just wraps.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (timeout_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    assign bridge.pprot = 3'b000;

    // NOTE: every register here updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            timeout_count        <= '0;
            bridge.psel          <= 1'b0;
            bridge.penable       <= 1'b0;
            bridge.pwrite        <= 1'b0;
            bridge.paddr         <= '0;
            bridge.pwdata        <= '0;
            bridge.pstrb         <= '0;
            bridge.bus_done      <= 1'b0;
            bridge.bus_read_data <= '0;
            bridge.bus_status    <= 2'b00;
        end else begin
            bridge.bus_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bridge.bus_request) begin
                        bridge.paddr  <= bridge.bus_address;
                        bridge.pwrite <= bridge.bus_direction;
                        bridge.pwdata <= bridge.bus_write_data;
                        bridge.pstrb  <= bridge.bus_direction ? bridge.bus_write_strobe : '0;
                        bridge.psel   <= 1'b1;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    bridge.penable <= 1'b1;
                    timeout_count  <= '0;
                    state          <= ACCESS;
                end
                ACCESS: begin
                    // A pready seen in the abort cycle still completes the transfer normally.
                    if (bridge.pready) begin
                        bridge.psel          <= 1'b0;
                        bridge.penable       <= 1'b0;
                        bridge.bus_read_data <= bridge.pwrite ? '0 : bridge.prdata;
                        bridge.bus_status    <= {bridge.pslverr, 1'b0};
                        bridge.bus_done      <= 1'b1;
                        state                <= RESPOND;
                    end else if (timeout_hit) begin
                        bridge.psel          <= 1'b0;
                        bridge.penable       <= 1'b0;
                        bridge.bus_read_data <= '0;
                        bridge.bus_status    <= 2'b11;
                        bridge.bus_done      <= 1'b1;
                        state                <= RESPOND;
                    end else begin
                        timeout_count <= timeout_count + COUNT_WIDTH'(1);
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Randomised scoreboard bench for rggen_apb_bridge: a timeout-enabled instance and a timeout-free one.
module tb_rggen_apb_bridge;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rggen_apb_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    rggen_apb_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    rggen_apb_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut_a (
        .clk(clk), .rst_n(rst_n), .bridge(ifa.master)
    );
    rggen_apb_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bridge(ifb.master)
    );

    typedef struct {
        logic          dir;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            wait_n;   // pready-low cycles before the completer answers
        logic          err;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    status;
        int            done_edge;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_done_edge = -100;
    txn_t apb_q[$];
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic dir, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] strb, input int wait_n, input logic err,
                                input logic [DW-1:0] rdata);
        txn_t t;
        t.dir = dir; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.wait_n = wait_n; t.err = err; t.rdata = rdata;
        return t;
    endfunction

    // Issues one request at a negedge and returns at the negedge where bus_done is seen.
    task automatic do_txn(input txn_t t);
        exp_t e;
        int   s;
        int   n;
        bit   to;
        // NOTE: stimulus is applied with blocking assignments at the negedge, clear of the sampling edge.
        ifa.bus_request      = 1'b1;
        ifa.bus_address      = t.addr;
        ifa.bus_direction    = t.dir;
        ifa.bus_write_data   = t.wdata;
        ifa.bus_write_strobe = t.strb;
        s  = (last_done_edge + 2 > cyc + 1) ? last_done_edge + 2 : cyc + 1;
        to = (t.wait_n >= T);
        e.status    = to ? 2'b11 : (t.err ? 2'b10 : 2'b00);
        e.rdata     = (to || t.dir) ? '0 : t.rdata;
        e.done_edge = to ? s + 1 + T : s + 2 + t.wait_n;
        last_done_edge = e.done_edge;
        exp_q.push_back(e);
        apb_q.push_back(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifa.bus_done && n < 200);
        if (!ifa.bus_done) begin
            checks++;
            failures++;
            $display("FAIL done_wait no bus_done within %0d cycles, expected by edge %0d", n, e.done_edge);
            exp_q.delete();
            apb_q.delete();
        end
        ifa.bus_request = 1'b0;
    endtask

    // Scoreboard monitor: every bus_done pops one expected response.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.bus_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done bus_done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("bus_status", ifa.bus_status, e.status);
                check("bus_read_data", ifa.bus_read_data, e.rdata);
                check("done_cycle", cyc, e.done_edge);
            end
        end
    end

    // APB completer for dut_a, also checking phase order and signal stability.
    txn_t cur;
    int   acc_cnt    = 0;
    bit   in_acc     = 1'b0;
    bit   prev_setup = 1'b0;

    always @(negedge clk) begin : completer_a
        if (!rst_n) begin
            ifa.pready = 1'b0; ifa.pslverr = 1'b0;
            in_acc = 1'b0; prev_setup = 1'b0; acc_cnt = 0;
        end else if (ifa.psel && !ifa.penable) begin
            check("setup_entry", {prev_setup, in_acc}, 2'b00);
            if (apb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_setup psel=1 with no queued request (cycle %0d)", cyc);
            end else begin
                cur = apb_q.pop_front();
            end
            prev_setup = 1'b1; in_acc = 1'b0; acc_cnt = 0;
            ifa.pready = 1'b0; ifa.pslverr = 1'b0;
        end else if (ifa.psel && ifa.penable) begin
            if (acc_cnt == 0) check("access_after_setup", prev_setup, 1'b1);
            prev_setup = 1'b0;
            in_acc     = 1'b1;
            check("paddr", ifa.paddr, cur.addr);
            check("pwrite", ifa.pwrite, cur.dir);
            check("pstrb", ifa.pstrb, cur.dir ? cur.strb : '0);
            check("pprot", ifa.pprot, 3'b000);
            if (cur.dir) check("pwdata", ifa.pwdata, cur.wdata);
            ifa.pready  = (acc_cnt == cur.wait_n);
            ifa.pslverr = ifa.pready & cur.err;
            ifa.prdata  = ifa.pready ? cur.rdata : DW'($urandom);
            acc_cnt++;
        end else begin
            if (in_acc) check("access_cycles", acc_cnt, (cur.wait_n >= T) ? T : cur.wait_n + 1);
            if (prev_setup) check("setup_to_access", ifa.penable, 1'b1);
            in_acc = 1'b0; prev_setup = 1'b0; acc_cnt = 0;
            ifa.pready = 1'b0; ifa.pslverr = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   r;
        int   n;
        bit   abort_seen;

        ifa.bus_request = 1'b0; ifa.bus_address = '0; ifa.bus_direction = 1'b0;
        ifa.bus_write_data = '0; ifa.bus_write_strobe = '0;
        ifa.pready = 1'b0; ifa.pslverr = 1'b0; ifa.prdata = '0;
        ifb.bus_request = 1'b0; ifb.bus_address = '0; ifb.bus_direction = 1'b0;
        ifb.bus_write_data = '0; ifb.bus_write_strobe = '0;
        ifb.pready = 1'b0; ifb.pslverr = 1'b0; ifb.prdata = '0;

        repeat (3) @(negedge clk);
        check("rst_psel", ifa.psel, 1'b0);
        check("rst_penable", ifa.penable, 1'b0);
        check("rst_pwrite", ifa.pwrite, 1'b0);
        check("rst_bus_done", ifa.bus_done, 1'b0);
        check("rst_paddr", ifa.paddr, '0);
        check("rst_pwdata", ifa.pwdata, '0);
        check("rst_pstrb", ifa.pstrb, '0);
        check("rst_pprot", ifa.pprot, '0);
        check("rst_read_data", ifa.bus_read_data, '0);
        check("rst_status", ifa.bus_status, 2'b00);
        check("rst_b_psel", ifb.psel, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Timeout disabled: 1000 wait cycles must not abort.
        ifb.bus_request = 1'b1; ifb.bus_address = 16'h0020; ifb.bus_direction = 1'b1;
        ifb.bus_write_data = 32'hCAFE_F00D; ifb.bus_write_strobe = 4'h3;
        n = 0;
        while (!(ifb.psel && ifb.penable) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b_access_reached", {ifb.psel, ifb.penable}, 2'b11);
        abort_seen = 1'b0;
        repeat (1000) begin
            if (ifb.bus_done || !ifb.psel) abort_seen = 1'b1;
            @(negedge clk);
        end
        check("b_no_abort", abort_seen, 1'b0);
        check("b_still_access", {ifb.psel, ifb.penable}, 2'b11);
        check("b_paddr", ifb.paddr, 16'h0020);
        check("b_pstrb", ifb.pstrb, 4'h3);
        ifb.pready = 1'b1;
        @(negedge clk);
        ifb.pready = 1'b0;
        check("b_done", ifb.bus_done, 1'b1);
        check("b_status", ifb.bus_status, 2'b00);
        check("b_read_data", ifb.bus_read_data, '0);
        ifb.bus_request = 1'b0;
        @(negedge clk);
        check("b_done_single", ifb.bus_done, 1'b0);

        // Directed transfers on dut_a.
        do_txn(mk(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0));
        @(negedge clk);
        do_txn(mk(1'b0, 16'h0014, 32'h1111_2222, 4'hF, 3, 1'b0, 32'h1234_5678));
        @(negedge clk);
        do_txn(mk(1'b1, 16'h0018, 32'h0BAD_0BAD, 4'h5, 1, 1'b1, 32'h0));
        @(negedge clk);
        do_txn(mk(1'b0, 16'h001C, 32'h0, 4'hF, 255, 1'b0, 32'h5555_AAAA));
        @(negedge clk);
        do_txn(mk(1'b0, 16'h0030, 32'h0, 4'h0, T - 1, 1'b0, 32'h7777_8888));
        @(negedge clk);
        // Back-to-back read/write/read on alternating addresses.
        do_txn(mk(1'b0, 16'h0040, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_0001));
        do_txn(mk(1'b1, 16'h0044, 32'h0000_BEEF, 4'hC, 0, 1'b0, 32'h0));
        do_txn(mk(1'b0, 16'h0040, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_0002));

        // Randomised traffic with random gaps, waits, errors and timeouts.
        for (int i = 0; i < 40; i++) begin
            t.dir   = 1'($urandom_range(0, 1));
            t.addr  = AW'($urandom);
            t.addr[1:0] = 2'b00;
            t.wdata = DW'($urandom);
            t.strb  = SW'($urandom);
            t.err   = ($urandom_range(0, 3) == 0);
            t.rdata = DW'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: t.wait_n = r;
                4, 5:       t.wait_n = $urandom_range(4, 6);
                6:          t.wait_n = T - 1;
                7:          t.wait_n = T;
                8:          t.wait_n = 255;
                default:    t.wait_n = 0;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn(t);
        end

        // Reset in the middle of ACCESS: psel drops at once and no bus_done follows.
        @(negedge clk);
        ifa.bus_request = 1'b1; ifa.bus_address = 16'h0050; ifa.bus_direction = 1'b0;
        ifa.bus_write_strobe = 4'hF;
        apb_q.push_back(mk(1'b0, 16'h0050, 32'h0, 4'hF, 255, 1'b0, 32'h0));
        n = 0;
        while (!(ifa.psel && ifa.penable) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_access_reached", {ifa.psel, ifa.penable}, 2'b11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_psel", ifa.psel, 1'b0);
        check("rst_mid_penable", ifa.penable, 1'b0);
        ifa.bus_request = 1'b0;
        apb_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (T + 4) @(negedge clk);
        check("rst_mid_no_done_pending", exp_q.size(), 0);
        last_done_edge = -100;
        do_txn(mk(1'b0, 16'h0054, 32'h0, 4'hF, 2, 1'b0, 32'h0F0F_1234));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rggen_apb_bridge.md
# rggen_apb_bridge

Converts a register-bus request (request/done handshake with direction, write strobe and 2-bit status) into an APB3/APB4 master transfer and returns the completion. It sits between an rggen host-side bus master and a downstream APB completer (sub-block register file or external APB peripheral). A per-transfer timeout guards against completers that never assert `pready`.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, width of `bus_address` / `paddr`
- DATA_WIDTH, 32, width of data buses; must be a multiple of 8
- TIMEOUT_CYCLES, 0, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- bus_request  input  1  transfer request; held high until `bus_done` is seen
- bus_address  input  ADDRESS_WIDTH  byte address
- bus_direction  input  1  0 = read, 1 = write
- bus_write_data  input  DATA_WIDTH  write data
- bus_write_strobe  input  DATA_WIDTH/8  byte enables
- bus_done  output  1  one-cycle completion pulse
- bus_read_data  output  DATA_WIDTH  read data; valid while `bus_done` is high
- bus_status  output  2  00 okay, 10 slave error, 11 timeout; valid while `bus_done` is high
- psel, penable, pwrite  output  1  APB controls
- paddr  output  ADDRESS_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- pstrb  output  DATA_WIDTH/8  APB strobes (forced to 0 for reads)
- pprot  output  3  constant 3'b000
- pready, pslverr  input  1  APB completer response
- prdata  input  DATA_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPOND.
- IDLE: when `bus_request` = 1, capture address, direction, write data and strobe into registers; go to SETUP.
- SETUP: psel=1, penable=0; always move to ACCESS after one cycle.
- ACCESS: psel=1, penable=1. If pready=1, capture prdata (reads only; writes capture 0) and status ({pslverr,0}); go to RESPOND. Otherwise increment the timeout counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES−1 without pready, abort: read data = 0, status = 11; go to RESPOND.
- RESPOND: psel=penable=0; bus_done=1 for exactly this cycle; go to IDLE.
- All APB and bus outputs are registered. paddr/pwrite/pwdata/pstrb hold their captured values from SETUP through the end of ACCESS and remain stable while pready=0.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1) (minimum 1); cleared in SETUP; counts only in ACCESS.
- pready sampled in the abort cycle wins: pready=1 completes normally.
- Requests arriving outside IDLE are ignored until IDLE is reached.

## Timing
- Reset (asynchronous, immediate): state IDLE; psel, penable, pwrite, bus_done = 0; paddr, pwdata, pstrb, pprot, bus_read_data, bus_status, timeout counter = 0.
- Reset mid-transfer: APB transfer abandoned with psel dropped immediately; no bus_done is issued.
- Zero-wait completer: request sampled at cycle N, SETUP at N+1, ACCESS at N+2 (pready=1), bus_done at N+3. Minimum latency is 3 cycles, and each pready wait cycle adds 1.
- Back-to-back: the requester drops bus_request the cycle after bus_done. IDLE at N+4 samples the next request, giving a 4-cycle minimum transfer period.
- Timeout: with TIMEOUT_CYCLES = T, ACCESS lasts at most T cycles, and bus_done appears T+2 cycles after the request is sampled.

## Test plan
- Write, zero wait: addr 0x0010, data 0xDEADBEEF, strb 0xF → psel at N+1, penable at N+2, pwrite=1, pstrb=0xF, bus_done at N+3, status 00.
- Read with 3 wait states: prdata 0x12345678 given with pready at the 4th ACCESS cycle → bus_read_data 0x12345678, status 00; paddr/pwrite stable for all ACCESS cycles; pstrb=0.
- Slave error: write with pslverr=1 alongside pready → status 10, bus_done single pulse.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 → psel drops after 8 ACCESS cycles, bus_done with status 11, read data 0. With TIMEOUT_CYCLES=0, 1000 wait cycles never abort.
- Back-to-back read/write/read on alternating addresses → each transfer has its own SETUP phase, with a 4-cycle period and no merged transfers.
- Assert rst_n low during ACCESS → psel/penable fall immediately, no bus_done; after release, a new read completes normally.
